// File: rtl/adder16_seq.sv
// Multi-cycle W-bit adder that time-multiplexes one external 16-bit adder,
// feeding it one slice per cycle (LSB first) with the carry chained through c_r.
module adder16_seq #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [16*WORDS-1:0] sum,
  output logic              cout,
  output logic              overflow,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_cin,
  input  logic [15:0]       add_sum,
  input  logic              add_cout
);
  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_r, b_r;
  logic          c_r;
  logic [15:0]   sel_a, sel_b;
  logic          last;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        sel_a = a_r[16*i +: 16];
        sel_b = b_r[16*i +: 16];
      end
    end
  end

  // adder inputs come only from registers, never from start
  assign add_a   = (state == RUN) ? sel_a : '0;
  assign add_b   = (state == RUN) ? sel_b : '0;
  assign add_cin = (state == RUN) ? c_r   : 1'b0;
  assign last    = (idx == IW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            c_r   <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++)
            if (idx == IW'(i)) sum[16*i +: 16] <= add_sum;
          c_r <= add_cout;
          if (last) begin
            cout     <= add_cout;
            overflow <= (a_r[W-1] == b_r[W-1]) && (add_sum[15] != a_r[W-1]);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder16_seq.sv
// Directed bench for adder16_seq: WORDS=4 and WORDS=1 instances, each wired
// to a behavioural 16-bit adder.
module tb_adder16_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WORDS=4 instance
  logic        start4, cin4, busy4, done4, cout4, ovf4, add_cin4, add_cout4;
  logic [63:0] a4, b4, sum4;
  logic [15:0] add_a4, add_b4, add_sum4;

  // WORDS=1 instance
  logic        start1, cin1, busy1, done1, cout1, ovf1, add_cin1, add_cout1;
  logic [15:0] a1, b1, sum1;
  logic [15:0] add_a1, add_b1, add_sum1;

  assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + 17'(add_cin4);
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + 17'(add_cin1);

  adder16_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4)
  );

  adder16_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start sampled at E0; done must appear only after E4
  task automatic op4(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic c, input logic [63:0] esum, input logic ecout,
                     input logic eovf);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk({tag, " busy@E0"}, 64'(busy4), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({tag, " done early"}, 64'(done4), 64'd0);
    end
    tick();
    chk({tag, " done@E4"}, 64'(done4), 64'd1);
    chk({tag, " sum"}, sum4, esum);
    chk({tag, " cout"}, 64'(cout4), 64'(ecout));
    chk({tag, " ovf"}, 64'(ovf4), 64'(eovf));
    tick();
    chk({tag, " done clr"}, 64'(done4), 64'd0);
    chk({tag, " busy clr"}, 64'(busy4), 64'd0);
  endtask

  task automatic op1(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input logic [15:0] esum, input logic ecout);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({tag, " done@E0"}, 64'(done1), 64'd0);
    tick();
    chk({tag, " done@E1"}, 64'(done1), 64'd1);
    chk({tag, " sum"}, 64'(sum1), 64'(esum));
    chk({tag, " cout"}, 64'(cout1), 64'(ecout));
    tick();
    chk({tag, " done clr"}, 64'(done1), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    chk("rst busy", 64'(busy4), 64'd0);
    chk("rst done", 64'(done4), 64'd0);
    chk("rst sum", sum4, 64'd0);
    chk("rst cout", 64'(cout4), 64'd0);
    chk("rst add_a", 64'(add_a4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // carry ripple across slices, observed slice by slice
    @(negedge clk);
    a4 = 64'h0000_0000_0000_FFFF; b4 = 64'h1; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("rip add_a s0", 64'(add_a4), 64'hFFFF);
    tick();
    chk("rip sum s0", sum4, 64'h0);
    chk("rip add_cin s1", 64'(add_cin4), 64'd1);
    tick();
    chk("rip sum s1", sum4, 64'h0000_0000_0001_0000);
    tick();
    tick();
    chk("rip done", 64'(done4), 64'd1);
    chk("rip sum", sum4, 64'h0000_0000_0001_0000);
    chk("rip cout", 64'(cout4), 64'd0);
    chk("rip ovf", 64'(ovf4), 64'd0);
    tick();
    chk("rip busy clr", 64'(busy4), 64'd0);

    op4("allF+cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    op4("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    op4("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);

    op1("w1 a", 16'hFF00, 16'h00FF, 1'b1, 16'h0000, 1'b1);
    op1("w1 b", 16'h03C3, 16'h00CF, 1'b1, 16'h0493, 1'b0);

    // start held high; operands change after capture
    @(negedge clk);
    a4 = 64'h0123_4567_89AB_CDEF; b4 = 64'h1111_1111_1111_1111; cin4 = 1'b0; start4 = 1'b1;
    tick();
    a4 = 64'hFFFF_0000_FFFF_0000; b4 = 64'h0001_0000_0001_0000;
    begin
      int ndone;
      ndone = 0;
      for (int k = 0; k <= 10; k++) begin
        if (k > 0) tick();
        chk($sformatf("hold busy k%0d", k), 64'(busy4), 64'(k != 5));
        chk($sformatf("hold done k%0d", k), 64'(done4), 64'(k == 4 || k == 10));
        if (done4) ndone++;
        if (k == 4) chk("hold sum1", sum4, 64'h1234_5678_9ABC_DF00);
        if (k == 10) begin
          chk("hold sum2", sum4, 64'h0000_0001_0000_0000);
          chk("hold cout2", 64'(cout4), 64'd1);
        end
      end
      start4 = 1'b0;
      chk("hold ndone", 64'(ndone), 64'd2);
    end
    tick();
    tick();
    chk("hold idle", 64'(busy4), 64'd0);

    // reset two cycles into RUN
    @(negedge clk);
    a4 = 64'h1111_2222_3333_4444; b4 = 64'h0101_0101_0101_0101; cin4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy4), 64'd0);
    chk("abort sum", sum4, 64'd0);
    chk("abort cout", 64'(cout4), 64'd0);
    chk("abort add_a", 64'(add_a4), 64'd0);
    chk("abort add_b", 64'(add_b4), 64'd0);
    chk("abort add_cin", 64'(add_cin4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (done4 || busy4) seen++;
      end
      chk("abort no done", 64'(seen), 64'd0);
    end
    op4("post rst", 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b1,
        64'h1212_2323_3434_4546, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
